// File: rtl/ps2_request_decoder.sv
// PS/2 set-2 byte stream to active-low request code for the traffic-light controller.
// Holds one latched request until acknowledged, cancelled with Esc, or timed out.
module ps2_request_decoder #(
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       ack,
    output logic [2:0] request,
    output logic       pending,
    output logic       error,
    output logic [3:0] drop_count
);

    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [2:0] REQ_NONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } frame_state_e;

    frame_state_e    state_q, state_d;
    logic [2:0]      request_q, request_d;
    logic            pending_q, pending_d;
    logic            error_q, error_d;
    logic [3:0]      drop_q, drop_d;
    logic [CW-1:0]   hold_q, hold_d;

    logic            make_valid;
    logic            is_prefix;
    logic            is_mapped;
    logic            is_esc;
    logic [2:0]      make_code;
    logic            timeout;
    logic            release_req;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        error_d    = 1'b0;
        make_valid = 1'b0;
        is_prefix  = (byte_data == BYTE_BRK) || (byte_data == BYTE_EXT);
        if (byte_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (byte_data == BYTE_BRK)      state_d = BRK;
                    else if (byte_data == BYTE_EXT) state_d = EXT;
                    else                            make_valid = 1'b1;
                end
                BRK: begin
                    state_d = IDLE;
                    error_d = is_prefix;
                end
                EXT: begin
                    if (byte_data == BYTE_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                        error_d = (byte_data == BYTE_EXT);
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    error_d = is_prefix;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        is_mapped = 1'b1;
        is_esc    = 1'b0;
        make_code = REQ_NONE;
        unique case (byte_data)
            8'h16:   make_code = 3'b110;
            8'h1E:   make_code = 3'b101;
            8'h26:   make_code = 3'b011;
            8'h76:   begin is_mapped = 1'b0; is_esc = 1'b1; end
            default: is_mapped = 1'b0;
        endcase
    end

    // A release (ack or timeout) frees the slot in the same cycle, so a coincident make latches.
    assign timeout     = pending_q && (HOLD_CYCLES != 0) && (hold_q == HOLD_LAST);
    assign release_req = pending_q && (ack || timeout);

    always_comb begin
        request_d = request_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        hold_d    = hold_q;
        if (pending_q && (HOLD_CYCLES != 0)) hold_d = hold_q + CW'(1);
        if (release_req) begin
            request_d = REQ_NONE;
            pending_d = 1'b0;
            hold_d    = '0;
        end
        if (make_valid && is_esc) begin
            request_d = REQ_NONE;
            pending_d = 1'b0;
            hold_d    = '0;
        end else if (make_valid && is_mapped) begin
            if (pending_q && !release_req) begin
                if (drop_q != 4'hF) drop_d = drop_q + 4'd1;
            end else begin
                request_d = make_code;
                pending_d = 1'b1;
                hold_d    = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            request_q <= REQ_NONE;
            pending_q <= 1'b0;
            error_q   <= 1'b0;
            drop_q    <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            request_q <= request_d;
            pending_q <= pending_d;
            error_q   <= error_d;
            drop_q    <= drop_d;
            hold_q    <= hold_d;
        end
    end

    assign request    = request_q;
    assign pending    = pending_q;
    assign error      = error_q;
    assign drop_count = drop_q;

endmodule
